// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder
//
// Turns the byte stream from a PS/2 receiver (scan-code set 2) into ASCII
// characters. It follows the make, break (F0) and extended (E0) prefixes. It
// keeps Shift and Caps Lock state and tracks the held key and a press count.
// Characters go into a show-ahead FIFO that the consumer drains with a
// valid/ready handshake.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   clrn         asynchronous active-low reset
//   code_valid   one-cycle strobe: code holds a received byte
//   code         received scan-code byte
//   out_ready    consumer takes the head entry this cycle
//   out_valid    FIFO non-empty
//   out_ascii    ASCII of the FIFO head (0 while empty)
//   out_code     make code of the FIFO head (0 while empty)
//   key_down     a mapped character key is currently held
//   cur_ascii    ASCII of the held key, 0 when none
//   caps_on      Caps Lock toggle state
//   press_count  new mapped key presses, wraps mod 2^CNT_W
//   overflow     sticky: a character was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module ps2_key_decoder #(
  parameter int FIFO_DEPTH = 8,   // power of two, >= 2
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             code_valid,
  input  logic [7:0]       code,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [7:0]       out_ascii,
  output logic [7:0]       out_code,
  output logic             key_down,
  output logic [7:0]       cur_ascii,
  output logic             caps_on,
  output logic [CNT_W-1:0] press_count,
  output logic             overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [7:0] SC_BREAK   = 8'hF0;
  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_SHIFT_L = 8'h12;
  localparam logic [7:0] SC_SHIFT_R = 8'h59;
  localparam logic [7:0] SC_CAPS    = 8'h58;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [AW:0]      PTR_ONE = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } dec_state_e;

  typedef struct packed {
    logic [7:0] code;
    logic [7:0] ascii;
  } entry_t;

  // -------------------------------------------------------------------------
  // Scan-code tables (US layout)
  // -------------------------------------------------------------------------
  // Unshifted character for a make code; 0 means the key is not a character.
  function automatic logic [7:0] base_ascii(input logic [7:0] c);
    logic [7:0] a;
    case (c)
      // letters a..z
      8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
      8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
      8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
      8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
      8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
      8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
      // digits 0..9
      8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
      8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
      8'h3E: a = 8'h38;  8'h46: a = 8'h39;
      // punctuation ` - = \ [ ] ; ' , . /
      8'h0E: a = 8'h60;  8'h4E: a = 8'h2D;  8'h55: a = 8'h3D;  8'h5D: a = 8'h5C;
      8'h54: a = 8'h5B;  8'h5B: a = 8'h5D;  8'h4C: a = 8'h3B;  8'h52: a = 8'h27;
      8'h41: a = 8'h2C;  8'h49: a = 8'h2E;  8'h4A: a = 8'h2F;
      // space, Enter
      8'h29: a = 8'h20;  8'h5A: a = 8'h0D;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  // Shifted form of digits and punctuation; anything else keeps its base
  // character (letters are handled separately because Caps Lock affects them).
  function automatic logic [7:0] shifted_ascii(input logic [7:0] c);
    logic [7:0] a;
    case (c)
      8'h45: a = 8'h29;  8'h16: a = 8'h21;  8'h1E: a = 8'h40;  8'h26: a = 8'h23;
      8'h25: a = 8'h24;  8'h2E: a = 8'h25;  8'h36: a = 8'h5E;  8'h3D: a = 8'h26;
      8'h3E: a = 8'h2A;  8'h46: a = 8'h28;
      8'h0E: a = 8'h7E;  8'h4E: a = 8'h5F;  8'h55: a = 8'h2B;  8'h5D: a = 8'h7C;
      8'h54: a = 8'h7B;  8'h5B: a = 8'h7D;  8'h4C: a = 8'h3A;  8'h52: a = 8'h22;
      8'h41: a = 8'h3C;  8'h49: a = 8'h3E;  8'h4A: a = 8'h3F;
      default: a = base_ascii(c);
    endcase
    return a;
  endfunction

  // -------------------------------------------------------------------------
  // Decoder state
  // -------------------------------------------------------------------------
  dec_state_e       state_q;
  logic             shift_l_q, shift_r_q;
  logic             caps_on_q, caps_held_q;
  logic             key_down_q;
  logic [7:0]       held_code_q;
  logic [7:0]       cur_ascii_q;
  logic [CNT_W-1:0] press_count_q;

  // Make-code classification for the byte on the input this cycle.
  logic [7:0] base_chr;
  logic [7:0] make_ascii_d;
  logic       is_make;
  logic       is_letter;
  logic       shift_held;
  logic       push;
  logic       new_press;

  // NOTE: every combinational output gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    base_chr     = base_ascii(code);
    shift_held   = shift_l_q | shift_r_q;
    is_letter    = (base_chr >= 8'h61) && (base_chr <= 8'h7A);
    make_ascii_d = base_chr;
    if (is_letter) begin
      if (shift_held ^ caps_on_q) make_ascii_d = base_chr - 8'h20;
    end else if (shift_held) begin
      make_ascii_d = shifted_ascii(code);
    end

    is_make   = code_valid && (state_q == ST_IDLE) &&
                (code != SC_BREAK) && (code != SC_EXT);
    // Modifiers map to 0 in the table, so they can never push.
    push      = is_make && (base_chr != 8'h00);
    // Typematic repeats of the held key still push but are not new presses.
    new_press = push && (!key_down_q || (code != held_code_q));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q       <= ST_IDLE;
      shift_l_q     <= 1'b0;
      shift_r_q     <= 1'b0;
      caps_on_q     <= 1'b0;
      caps_held_q   <= 1'b0;
      key_down_q    <= 1'b0;
      held_code_q   <= 8'h00;
      cur_ascii_q   <= 8'h00;
      press_count_q <= '0;
    end else if (code_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (code == SC_BREAK) begin
            state_q <= ST_BRK;
          end else if (code == SC_EXT) begin
            state_q <= ST_EXT;
          end else begin
            case (code)
              SC_SHIFT_L: shift_l_q <= 1'b1;
              SC_SHIFT_R: shift_r_q <= 1'b1;
              SC_CAPS: begin
                // Only the first make of a hold toggles; repeats are ignored.
                if (!caps_held_q) caps_on_q <= ~caps_on_q;
                caps_held_q <= 1'b1;
              end
              default: begin
                if (push) begin
                  key_down_q  <= 1'b1;
                  held_code_q <= code;
                  cur_ascii_q <= make_ascii_d;
                  if (new_press) press_count_q <= press_count_q + CNT_ONE;
                end
              end
            endcase
          end
        end

        ST_BRK: begin
          state_q <= ST_IDLE;
          if (code == SC_SHIFT_L) shift_l_q   <= 1'b0;
          if (code == SC_SHIFT_R) shift_r_q   <= 1'b0;
          if (code == SC_CAPS)    caps_held_q <= 1'b0;
          if (code == held_code_q) begin
            key_down_q  <= 1'b0;
            cur_ascii_q <= 8'h00;
          end
        end

        // Extended keys (arrows, right Ctrl, ...) are swallowed entirely.
        ST_EXT:     state_q <= (code == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
        ST_EXT_BRK: state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  assign key_down    = key_down_q;
  assign cur_ascii   = cur_ascii_q;
  assign caps_on     = caps_on_q;
  assign press_count = press_count_q;

  // -------------------------------------------------------------------------
  // Character FIFO (show-ahead)
  // -------------------------------------------------------------------------
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        overflow_q;
  entry_t      mem_q [FIFO_DEPTH];
  entry_t      head;

  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic wr_en;
  logic drop;

  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop        = !fifo_empty && out_ready;
    // A pop in the same cycle frees the slot the push needs.
    wr_en      = push && (!fifo_full || pop);
    drop       = push && fifo_full && !pop;
    wr_ptr_d   = wr_en ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d   = pop   ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_q | drop;
    end
  end

  // NOTE: the storage array has no reset; an entry is only observable after
  // it has been written, and the outputs are forced to 0 while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= '{code: code, ascii: make_ascii_d};
  end

  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign out_valid = !fifo_empty;
  assign out_ascii = fifo_empty ? 8'h00 : head.ascii;
  assign out_code  = fifo_empty ? 8'h00 : head.code;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_decoder
//
// Directed scenarios with fixed expectations, followed by a randomized byte
// stream checked cycle by cycle against a behavioural keyboard model. The
// model's character tables are built from plain strings of the US layout.
// ---------------------------------------------------------------------------
module tb_ps2_key_decoder;

  localparam int DEPTH = 8;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          clrn = 1'b0;
  logic          code_valid = 1'b0;
  logic [7:0]    code = 8'h00;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [7:0]    out_ascii;
  logic [7:0]    out_code;
  logic          key_down;
  logic [7:0]    cur_ascii;
  logic          caps_on;
  logic [CW-1:0] press_count;
  logic          overflow;

  int errors = 0;
  int checks = 0;

  ps2_key_decoder #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .clrn(clrn), .code_valid(code_valid), .code(code),
    .out_ready(out_ready), .out_valid(out_valid), .out_ascii(out_ascii),
    .out_code(out_code), .key_down(key_down), .cur_ascii(cur_ascii),
    .caps_on(caps_on), .press_count(press_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  logic [7:0] lo_tab [logic [7:0]];
  logic [7:0] hi_tab [logic [7:0]];
  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B,
    8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
    8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  string letters = "abcdefghijklmnopqrstuvwxyz";

  bit          m_brk, m_ext;
  bit          m_shl, m_shr, m_caps, m_caps_held, m_down;
  logic [7:0]  m_held, m_cur;
  logic [CW-1:0] m_cnt;
  bit          m_ovf;
  logic [15:0] exp_q [$];

  task automatic init_tables();
    logic [7:0] dc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                            8'h3D, 8'h3E, 8'h46};
    logic [7:0] pc [9] = '{8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h4C,
                           8'h41, 8'h49, 8'h4A};
    string dl = "0123456789";
    string dh = ")!@#$%^&*(";
    string pl = "`-=[];,./";
    string ph = "~_+{}:<>?";
    for (int i = 0; i < 26; i++) lo_tab[letter_codes[i]] = letters[i];
    for (int i = 0; i < 10; i++) begin
      lo_tab[dc[i]] = dl[i];
      hi_tab[dc[i]] = dh[i];
    end
    for (int i = 0; i < 9; i++) begin
      lo_tab[pc[i]] = pl[i];
      hi_tab[pc[i]] = ph[i];
    end
    lo_tab[8'h5D] = 8'h5C;
    hi_tab[8'h5D] = 8'h7C;
    lo_tab[8'h52] = 8'h27;
    hi_tab[8'h52] = 8'h22;
    lo_tab[8'h29] = 8'h20;
    lo_tab[8'h5A] = 8'h0D;
  endtask

  task automatic model_reset();
    m_brk = 0; m_ext = 0; m_shl = 0; m_shr = 0; m_caps = 0; m_caps_held = 0;
    m_down = 0; m_held = 8'h00; m_cur = 8'h00; m_cnt = '0; m_ovf = 0;
    exp_q.delete();
  endtask

  // Applies one received byte to the model; reports a character to enqueue.
  task automatic model_byte(input logic [7:0] b, output bit push,
                            output logic [15:0] ent);
    logic [7:0] a;
    bit sh;
    push = 0;
    ent  = 16'h0000;
    if (m_ext && m_brk) begin
      m_ext = 0; m_brk = 0;
    end else if (m_ext) begin
      if (b == 8'hF0) m_brk = 1;
      else            m_ext = 0;
    end else if (m_brk) begin
      m_brk = 0;
      if (b == 8'h12) m_shl = 0;
      if (b == 8'h59) m_shr = 0;
      if (b == 8'h58) m_caps_held = 0;
      if (b == m_held) begin m_down = 0; m_cur = 8'h00; end
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'h12) begin
      m_shl = 1;
    end else if (b == 8'h59) begin
      m_shr = 1;
    end else if (b == 8'h58) begin
      if (!m_caps_held) m_caps = !m_caps;
      m_caps_held = 1;
    end else if (lo_tab.exists(b)) begin
      sh = m_shl || m_shr;
      a  = lo_tab[b];
      if (a >= "a" && a <= "z") begin
        if (sh != m_caps) a = a - 8'd32;
      end else if (sh && hi_tab.exists(b)) begin
        a = hi_tab[b];
      end
      push = 1;
      ent  = {b, a};
      if (!m_down || b != m_held) m_cnt = m_cnt + 1'b1;
      m_down = 1; m_held = b; m_cur = a;
    end
  endtask

  // One clock cycle: inputs applied at the falling edge, the model advanced
  // at the rising edge, and control returned at the next falling edge.
  task automatic cyc(input logic v, input logic [7:0] c, input logic r);
    bit push;
    logic [15:0] ent;
    code_valid = v; code = c; out_ready = r;
    @(posedge clk);
    if (r && exp_q.size() != 0) void'(exp_q.pop_front());
    if (v) begin
      model_byte(c, push, ent);
      if (push) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(ent);
        else m_ovf = 1;
      end
    end
    @(negedge clk);
    code_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic send(input logic [7:0] c);
    cyc(1'b1, c, 1'b0);
  endtask

  // Samples the head and removes it (no comparison here).
  task automatic pop_entry(output logic v, output logic [7:0] a,
                           output logic [7:0] c);
    v = out_valid; a = out_ascii; c = out_code;
    cyc(1'b0, 8'h00, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clrn = 1'b0; code_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clrn = 1'b1;
    model_reset();
  endtask

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    send(8'h1C); send(8'h58); send(8'hF0);
    clrn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_ascii !== 8'h00) begin errors++; $display("FAIL reset_out_ascii got=%h exp=00", out_ascii); end
    checks++; if (out_code !== 8'h00) begin errors++; $display("FAIL reset_out_code got=%h exp=00", out_code); end
    checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL reset_key_down got=%0b exp=0", key_down); end
    checks++; if (cur_ascii !== 8'h00) begin errors++; $display("FAIL reset_cur_ascii got=%h exp=00", cur_ascii); end
    checks++; if (caps_on !== 1'b0) begin errors++; $display("FAIL reset_caps_on got=%0b exp=0", caps_on); end
    checks++; if (press_count !== 8'd0) begin errors++; $display("FAIL reset_press_count got=%0d exp=0", press_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
    @(negedge clk);
    clrn = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    logic v; logic [7:0] a, c;
    do_reset();
    send(8'h1C);
    checks++; if (key_down !== 1'b1) begin errors++; $display("FAIL basic_key_down_make got=%0b exp=1", key_down); end
    checks++; if (cur_ascii !== 8'h61) begin errors++; $display("FAIL basic_cur_ascii got=%h exp=61", cur_ascii); end
    checks++; if (press_count !== 8'd1) begin errors++; $display("FAIL basic_press_count got=%0d exp=1", press_count); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid_latency got=%0b exp=1", out_valid); end
    send(8'hF0); send(8'h1C);
    checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL basic_key_down_break got=%0b exp=0", key_down); end
    checks++; if (cur_ascii !== 8'h00) begin errors++; $display("FAIL basic_cur_ascii_break got=%h exp=00", cur_ascii); end
    pop_entry(v, a, c);
    checks++; if ({v, a, c} !== {1'b1, 8'h61, 8'h1C}) begin errors++; $display("FAIL basic_entry got=%0b/%h/%h exp=1/61/1C", v, a, c); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_single_entry got=%0b exp=0", out_valid); end
  endtask

  task automatic test_shift();
    logic v; logic [7:0] a, c;
    do_reset();
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    pop_entry(v, a, c);
    checks++; if ({v, a, c} !== {1'b1, 8'h41, 8'h1C}) begin errors++; $display("FAIL shift_upper got=%0b/%h/%h exp=1/41/1C", v, a, c); end
    send(8'h1C);
    pop_entry(v, a, c);
    checks++; if ({v, a} !== {1'b1, 8'h61}) begin errors++; $display("FAIL shift_released got=%0b/%h exp=1/61", v, a); end
  endtask

  task automatic test_caps();
    logic v; logic [7:0] a, c;
    do_reset();
    send(8'h58); send(8'hF0); send(8'h58); send(8'h1C);
    send(8'h12); send(8'h1C);
    checks++; if (caps_on !== 1'b1) begin errors++; $display("FAIL caps_toggle_on got=%0b exp=1", caps_on); end
    pop_entry(v, a, c);
    checks++; if ({v, a} !== {1'b1, 8'h41}) begin errors++; $display("FAIL caps_upper got=%0b/%h exp=1/41", v, a); end
    pop_entry(v, a, c);
    checks++; if ({v, a} !== {1'b1, 8'h61}) begin errors++; $display("FAIL caps_shift_lower got=%0b/%h exp=1/61", v, a); end
    send(8'hF0); send(8'h12);
    send(8'h58); send(8'h58);
    checks++; if (caps_on !== 1'b0) begin errors++; $display("FAIL caps_repeat_once got=%0b exp=0", caps_on); end
    send(8'hF0); send(8'h58); send(8'h58);
    checks++; if (caps_on !== 1'b1) begin errors++; $display("FAIL caps_retoggle got=%0b exp=1", caps_on); end
  endtask

  task automatic test_punct_typematic();
    logic v; logic [7:0] a, c;
    logic [7:0] exp_a [4] = '{8'h21, 8'h61, 8'h61, 8'h61};
    do_reset();
    send(8'h12); send(8'h16); send(8'hF0); send(8'h12);
    send(8'h1C); send(8'h1C); send(8'h1C);
    checks++; if (press_count !== 8'd2) begin errors++; $display("FAIL typematic_count got=%0d exp=2", press_count); end
    for (int i = 0; i < 4; i++) begin
      pop_entry(v, a, c);
      checks++; if ({v, a} !== {1'b1, exp_a[i]}) begin errors++; $display("FAIL punct_entry%0d got=%0b/%h exp=1/%h", i, v, a, exp_a[i]); end
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL typematic_extra_entry got=%0b exp=0", out_valid); end
  endtask

  task automatic test_extended();
    do_reset();
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    checks++; if ({out_valid, key_down} !== 2'b00) begin errors++; $display("FAIL ext_no_entry got=%b exp=00", {out_valid, key_down}); end
    checks++; if (press_count !== 8'd0) begin errors++; $display("FAIL ext_count got=%0d exp=0", press_count); end
    send(8'h1C);
    checks++; if ({out_valid, out_ascii} !== {1'b1, 8'h61}) begin errors++; $display("FAIL ext_back_idle got=%0b/%h exp=1/61", out_valid, out_ascii); end
    send(8'hF0);
    do_reset();
    send(8'h1C);
    checks++; if ({out_valid, out_ascii, key_down} !== {1'b1, 8'h61, 1'b1}) begin errors++; $display("FAIL reset_prefix got=%0b/%h/%0b exp=1/61/1", out_valid, out_ascii, key_down); end
  endtask

  task automatic test_overflow();
    logic v; logic [7:0] a, c;
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++) send(letter_codes[i]);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%0b exp=1", overflow); end
    checks++; if (press_count !== 8'(DEPTH + 2)) begin errors++; $display("FAIL ovf_count got=%0d exp=%0d", press_count, DEPTH + 2); end
    for (int i = 0; i < DEPTH; i++) begin
      pop_entry(v, a, c);
      checks++; if ({v, a, c} !== {1'b1, 8'(letters[i]), letter_codes[i]}) begin errors++; $display("FAIL ovf_order%0d got=%0b/%h/%h exp=1/%h/%h", i, v, a, c, 8'(letters[i]), letter_codes[i]); end
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got=%0b exp=0", out_valid); end

    do_reset();
    for (int i = 0; i < DEPTH; i++) send(letter_codes[i]);
    cyc(1'b1, letter_codes[DEPTH], 1'b1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_push_pop_ovf got=%0b exp=0", overflow); end
    for (int i = 1; i <= DEPTH; i++) begin
      pop_entry(v, a, c);
      checks++; if ({v, c} !== {1'b1, letter_codes[i]}) begin errors++; $display("FAIL full_push_pop_order%0d got=%0b/%h exp=1/%h", i, v, c, letter_codes[i]); end
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_push_pop_drained got=%0b exp=0", out_valid); end
  endtask

  // Random byte stream (back-to-back strobes most cycles, random ready).
  task automatic test_random();
    logic [7:0] pool [24] = '{8'h1C, 8'h32, 8'h21, 8'h16, 8'h1E, 8'h45, 8'h4E,
      8'h5D, 8'h52, 8'h4A, 8'h0E, 8'h29, 8'h5A, 8'h12, 8'h59, 8'h58, 8'hF0,
      8'hF0, 8'hE0, 8'h05, 8'h75, 8'h1C, 8'h1C, 8'h41};
    logic v, r;
    logic [7:0] c;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      v = ($urandom_range(0, 4) != 0);
      r = ($urandom_range(0, 2) == 0);
      c = pool[$urandom_range(0, 23)];
      cyc(v, c, r);
      checks++; if (out_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rand_out_valid n=%0d got=%0b exp=%0b", n, out_valid, exp_q.size() != 0); end
      if (exp_q.size() != 0) begin
        checks++; if ({out_code, out_ascii} !== exp_q[0]) begin errors++; $display("FAIL rand_head n=%0d got=%h%h exp=%h", n, out_code, out_ascii, exp_q[0]); end
      end
      checks++; if ({key_down, cur_ascii} !== {m_down, m_cur}) begin errors++; $display("FAIL rand_held n=%0d got=%0b/%h exp=%0b/%h", n, key_down, cur_ascii, m_down, m_cur); end
      checks++; if (caps_on !== m_caps) begin errors++; $display("FAIL rand_caps n=%0d got=%0b exp=%0b", n, caps_on, m_caps); end
      checks++; if (press_count !== m_cnt) begin errors++; $display("FAIL rand_count n=%0d got=%0d exp=%0d", n, press_count, m_cnt); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rand_overflow n=%0d got=%0b exp=%0b", n, overflow, m_ovf); end
    end
  endtask

  initial begin
    init_tables();
    model_reset();
    test_reset();
    test_basic();
    test_shift();
    test_caps();
    test_punct_typematic();
    test_extended();
    test_overflow();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Sequential PS/2 set-2 keystroke decoder that sits between the PS/2 receiver (byte stream) and downstream consumers (display, console). Tracks make/break/extended prefixes, Shift and Caps Lock state, held key and press count, and queues ASCII characters in a parametrised FIFO with a valid/ready output handshake. Generalises the combinational scan-code-to-ASCII table with modifier-aware case, shifted punctuation, and buffering.

## Interface
- FIFO_DEPTH, 8, character FIFO entries; power of two, >= 2
- CNT_W, 8, width of press counter
- clk  in  1  system clock, all state on rising edge
- clrn  in  1  asynchronous active-low reset
- code_valid  in  1  one-cycle strobe: code holds a received byte
- code  in  8  received scan-code byte
- out_ready  in  1  consumer accepts head entry this cycle
- out_valid  out  1  FIFO non-empty
- out_ascii  out  8  ASCII of FIFO head (show-ahead)
- out_code  out  8  make code of FIFO head
- key_down  out  1  a mapped character key is currently held
- cur_ascii  out  8  ASCII of held key, 0 when none
- caps_on  out  1  Caps Lock toggle state
- press_count  out  CNT_W  count of new mapped key presses, wraps mod 2^CNT_W
- overflow  out  1  sticky: a character was dropped because FIFO full

## Operation
- Decoder FSM, advances only on code_valid: IDLE, BRK, EXT, EXT_BRK.
- IDLE: F0 -> BRK; E0 -> EXT; any other byte is a make code, stay IDLE.
- BRK: byte is a released code -> IDLE. 12/59 clear shift_l/shift_r; 58 clears caps_held; code equal to held code clears key_down, cur_ascii=0. Nothing pushed.
- EXT: F0 -> EXT_BRK; other byte ignored -> IDLE. EXT_BRK: any byte ignored -> IDLE. Extended keys never push or count.
- Make handling (IDLE): 12/59 set shift_l/shift_r; 58 toggles caps_on only if caps_held=0, then sets caps_held (typematic repeat does not re-toggle). Modifiers never push.
- Mapped make: unshifted US layout — letters lowercase, digits, ` - = \ [ ] ; ' , . /, space 0x20, Enter 0x0D (5A). Unmapped code (ASCII 0): no push, no count, no key_down change.
- Case: letters uppercase when (shift_l|shift_r) XOR caps_on. Non-letters use shifted form when shift held (caps irrelevant): 1! 2@ 3# 4$ 5% 6^ 7& 8* 9( 0) -_ =+ \| [{ ]} ;: '" ,< .> /? `~. Space/Enter unchanged.
- Every mapped make (including typematic repeats) pushes {code, ascii}. press_count increments only if key_down=0 or code != held code; then key_down=1, held code/cur_ascii updated.
- FIFO: push if not full or pop same cycle; otherwise entry dropped, overflow set until reset. Pop when out_valid & out_ready. Push+pop when empty: entry enters, out_valid next cycle. Pointers wrap at FIFO_DEPTH.

## Timing
- Reset (clrn low, async): FSM IDLE, FIFO empty, out_valid=0, out_ascii=0, out_code=0, key_down=0, cur_ascii=0, caps_on=0, press_count=0, overflow=0, shift/caps_held cleared. Reset mid-sequence (after F0/E0) discards the prefix; next byte decoded from IDLE.
- Byte strobed at edge N: FSM, modifiers, key_down, cur_ascii, caps_on, press_count, FIFO write all updated at edge N; out_valid visible after edge N (1-cycle latency into empty FIFO).
- Pop takes effect at the edge where out_valid & out_ready; next entry presented immediately after.
- out_ascii/out_code undefined-free: hold head data; hold last value is not required when out_valid=0 (bench checks only when valid).
- code_valid may assert back-to-back every cycle; no byte is lost in the decoder.

## Test plan
- Bytes 1C, F0 1C -> one entry ascii 61 code 1C; press_count=1; key_down 1 then 0.
- 12, 1C, F0 1C, F0 12 -> entry 41 ('A'); shift released; next 1C -> 61.
- 58, F0 58, 1C, then 12 1C -> caps_on=1, entries 41 then 61; repeated 58 58 while held toggles once.
- 12, 16 -> entry 21 ('!'); 1C 1C 1C (typematic) -> three 61 entries, press_count +1 only.
- E0 75, E0 F0 75 (up arrow) -> no entry, count unchanged, FSM back to IDLE; reset after lone F0, then 1C -> entry 61.
- out_ready=0, FIFO_DEPTH+2 mapped makes -> FIFO_DEPTH entries kept in order, overflow=1; drain with out_ready=1 -> out_valid drops after FIFO_DEPTH pops; simultaneous push+pop when full keeps overflow 0.
